xosera_bus_responder: RTL and testbench
=======================================

Name: xosera_bus_responder

Overview:
- Bus-side responder for the asynchronous 8-bit 68K-style register bus; it sits between the external bus pins and the register and blitter logic in xosera_main.
- Synchronizes and deglitches the chip-select strobe and captures the register number, byte select, direction and write data.
- Assembles byte writes into 16-bit register writes and issues one-clock read and write strobes.
- Holds a captured 16-bit read word so that high-byte then low-byte reads return a consistent word.

Parameters:
- SYNC_STAGES, 2: flip-flop synchronizer depth on bus_cs_n_i (minimum 2).
- CS_FILTER, 2: consecutive synchronized samples of cs_n that must agree before a level change is accepted (minimum 1).

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- reset_n_i  in  1  asynchronous, active-low reset.
- bus_cs_n_i  in  1  chip select, active low, asynchronous to clk.
- bus_rd_nwr_i  in  1  1 = read, 0 = write; stable while cs asserted.
- bus_reg_num_i  in  4  register number; stable while cs asserted.
- bus_bytesel_i  in  1  0 = high byte, 1 = low byte.
- bus_data_i  in  8  write data; stable while cs asserted.
- bus_data_o  out  8  read data byte.
- bus_data_oe_o  out  1  high while a read cycle is active (drives pad tristate).
- reg_wr_strobe_o  out  1  one-clock pulse per accepted write.
- reg_rd_strobe_o  out  1  one-clock pulse per accepted high-byte read.
- reg_num_o  out  4  latched register number.
- reg_bytesel_o  out  1  latched byte select.
- reg_data_o  out  16  write word {hi_latch, low byte}.
- reg_rd_data_i  in  16  register read word; valid exactly 1 clk after reg_rd_strobe_o.

Behaviour:
- **Reset.** Asynchronous, active-low. All sync flops are set to 1 (cs deasserted) and the FSM goes to RESYNC. All outputs reset to 0: bus_data_o, bus_data_oe_o, both strobes, reg_num_o, reg_bytesel_o, reg_data_o. hi_latch and rd_word also reset to 0.
- **Synchronizer.** bus_cs_n_i passes through SYNC_STAGES flops to give cs_s. The filtered level cs_f changes only after CS_FILTER consecutive cs_s samples that differ from the current cs_f.
- **Bus fields.** bus_rd_nwr_i, bus_reg_num_i, bus_bytesel_i and bus_data_i are not synchronized. They are sampled only in the clk on which cs_f falls, when they are guaranteed stable.
- **FSM state RESYNC.** Wait until cs_f == 1, then go to IDLE. If reset is released mid-cycle (cs already low), that cycle produces no strobe.
- **FSM state IDLE.** On cs_f 1→0:
  - Latch reg_num_o, reg_bytesel_o, rd_nwr and data byte.
  - Go to ACTIVE.
  - Pulse the appropriate strobe in the next clk (see write path and read path).
- **FSM state ACTIVE.** On cs_f 0→1:
  - Deassert bus_data_oe_o.
  - Go to IDLE.
  - A new cycle is accepted no sooner than the next cs_f fall.
- **Write path, high byte (bytesel=0).**
  - hi_latch ← data.
  - reg_data_o ← {data, reg_data_o[7:0]}.
  - reg_wr_strobe_o = 1 for one clk.
- **Write path, low byte (bytesel=1).**
  - reg_data_o ← {hi_latch, data}.
  - reg_wr_strobe_o = 1 for one clk.
  - hi_latch is unchanged.
- **Read path, high byte (bytesel=0).**
  - reg_rd_strobe_o = 1 for one clk.
  - The next clk captures rd_word ← reg_rd_data_i.
  - bus_data_o ← reg_rd_data_i[15:8] in that same clk.
- **Read path, low byte (bytesel=1).**
  - No strobe.
  - bus_data_o ← rd_word[7:0] from the most recent high-byte read; this is 0 after reset.
- **Read output enable.** bus_data_oe_o = 1 from the clk after the cs_f fall until the cs_f rise, reads only. bus_data_o holds its value until the next read updates it.
- **Latency.** From a bus_cs_n_i fall to the strobe: SYNC_STAGES + CS_FILTER + 1 clks, ±1 for metastability. At the defaults this is 5 clks. The bus cycle (cs low ≥ 333 ns) must exceed the latency plus 1 clk of read capture.
- **Glitch rejection.** A cs low pulse shorter than CS_FILTER synchronized samples is ignored: no strobe and no latch update.
- **Simultaneous events.** Strobes are mutually exclusive, since one cycle is either a read or a write. A reset during ACTIVE aborts the cycle with no further strobes.

Decomposition:
- xosera_pkg:
  - bus FSM state enum (RESYNC, IDLE, ACTIVE);
  - constants BUS_BYTE_HI = 0 and BUS_BYTE_LO = 1;
  - reg_num width (4).
- Sub-module xosera_sync_filter: parameterized SYNC_STAGES synchronizer plus CS_FILTER agreement filter. It outputs the filtered level and one-clk fall and rise pulses, and its sync flops reset to 1.

Test Plan:
- Write hi 0x12 then lo 0x34 to reg 3 (68K timing, 83.333 ns period) → two reg_wr_strobe_o pulses, reg_num_o=3 each time. After the second pulse reg_data_o=0x1234 with reg_bytesel_o=1.
- With reg_rd_data_i=0xBEEF, read hi of reg 1 → reg_rd_strobe_o once, bus_data_o=0xBE, oe high only while cs low. Then set reg_rd_data_i=0x0000 and read lo → bus_data_o=0xEF with no strobe.
- Hold bus_cs_n_i low, pulse reset_n_i low for 3 clks, release → zero strobes until cs rises. The next full cycle strobes normally.
- Drive a 1-clk low glitch on bus_cs_n_i → no strobe; reg_num_o and reg_data_o unchanged.
- Back-to-back writes with 4 × 83.333 ns gaps (hi 0xDA, lo 0x7A, reg 2) → exactly 2 strobes, reg_data_o=0xDA7A. Strobe latency measured at 5±1 clks from cs fall.
- Write lo 0x55 after reset with no prior hi write → reg_data_o=0x0055.

Source files
------------

// File: rtl/xosera_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xosera_pkg
//  Description : Shared types and constants for the Xosera bus responder.
//  Revision    : 1.0  initial release
// ============================================================================
package xosera_pkg;

    // Width of the register number carried on the host bus
    localparam int REG_NUM_W = 4;

    // Byte-select encoding on the host bus
    localparam logic BUS_BYTE_HI = 1'b0;
    localparam logic BUS_BYTE_LO = 1'b1;

    // Bus-cycle tracking state
    typedef enum logic [1:0] {
        BUS_RESYNC = 2'd0,
        BUS_IDLE   = 2'd1,
        BUS_ACTIVE = 2'd2
    } bus_state_e;

endpackage
`default_nettype wire

// File: rtl/xosera_bus_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : xosera_bus_responder_if
//  Description : External 8-bit 68K-style register bus pins as seen by the
//                responder (slave) and by the host driving them (master).
//  Revision    : 1.0  initial release
// ============================================================================
interface xosera_bus_responder_if;
    import xosera_pkg::*;

    logic                 bus_cs_n_i;
    logic                 bus_rd_nwr_i;
    logic [REG_NUM_W-1:0] bus_reg_num_i;
    logic                 bus_bytesel_i;
    logic [7:0]           bus_data_i;
    logic [7:0]           bus_data_o;
    logic                 bus_data_oe_o;

    // Responder side
    modport slave (
        input  bus_cs_n_i,
        input  bus_rd_nwr_i,
        input  bus_reg_num_i,
        input  bus_bytesel_i,
        input  bus_data_i,
        output bus_data_o,
        output bus_data_oe_o
    );

    // Host side
    modport master (
        output bus_cs_n_i,
        output bus_rd_nwr_i,
        output bus_reg_num_i,
        output bus_bytesel_i,
        output bus_data_i,
        input  bus_data_o,
        input  bus_data_oe_o
    );

endinterface
`default_nettype wire

// File: rtl/xosera_sync_filter.sv
`default_nettype none
// ============================================================================
//  Module      : xosera_sync_filter
//  Description : Multi-flop synchronizer followed by an agreement filter; the
//                filtered level only moves after CS_FILTER consecutive
//                synchronized samples disagree with it. Emits one-clock
//                fall/rise pulses aligned with the level change.
//  Revision    : 1.0  initial release
// ============================================================================
module xosera_sync_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int CS_FILTER   = 2
) (
    input  wire logic clk,
    input  wire logic reset_n_i,
    input  wire logic async_i,
    output logic      level_o,
    output logic      fall_o,
    output logic      rise_o
);

    localparam int CNT_W = (CS_FILTER > 1) ? $clog2(CS_FILTER) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   cs_s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   fall_q, fall_d;
    logic                   rise_q, rise_d;

    // Synchronizer chain; idles high so a reset looks like "deselected"
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
        end
    end

    assign cs_s = sync_q[SYNC_STAGES-1];

    // Count consecutive disagreeing samples; flip the level when enough agree
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        fall_d  = 1'b0;
        rise_d  = 1'b0;
        if (cs_s != level_q) begin
            if (cnt_q == CNT_W'(CS_FILTER - 1)) begin
                level_d = cs_s;
                fall_d  = ~cs_s;
                rise_d  = cs_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Filter state registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q   <= '0;
            level_q <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            fall_q  <= fall_d;
            rise_q  <= rise_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;
    assign rise_o  = rise_q;

endmodule
`default_nettype wire

// File: rtl/xosera_bus_responder.sv
`default_nettype none
// ============================================================================
//  Module      : xosera_bus_responder
//  Description : Host bus responder. Filters chip select, captures bus fields
//                on the filtered falling edge, assembles byte writes into
//                16-bit register writes and serves high/low byte reads from a
//                word captured at the high-byte read.
//  Revision    : 1.0  initial release
// ============================================================================
module xosera_bus_responder
    import xosera_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CS_FILTER   = 2
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n_i,
    xosera_bus_responder_if.slave     bus,
    output logic                      reg_wr_strobe_o,
    output logic                      reg_rd_strobe_o,
    output logic [REG_NUM_W-1:0]      reg_num_o,
    output logic                      reg_bytesel_o,
    output logic [15:0]               reg_data_o,
    input  wire logic [15:0]          reg_rd_data_i
);

    // After reset, the synchronizer and filter need this many clocks before
    // the filtered level reflects the pin; RESYNC waits this out so a cycle
    // already in progress at reset release is never mistaken for a new one.
    localparam int SETTLE   = SYNC_STAGES + CS_FILTER;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    logic cs_level;
    logic cs_fall;
    logic cs_rise;

    bus_state_e          state_q, state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    logic                 wr_strobe_q, wr_strobe_d;
    logic                 rd_strobe_q, rd_strobe_d;
    logic [REG_NUM_W-1:0] reg_num_q, reg_num_d;
    logic                 bytesel_q, bytesel_d;
    logic [15:0]          reg_data_q, reg_data_d;
    logic [7:0]           hi_latch_q, hi_latch_d;
    logic [15:0]          rd_word_q, rd_word_d;
    logic [7:0]           bus_data_q, bus_data_d;
    logic                 oe_q, oe_d;

    xosera_sync_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .CS_FILTER   (CS_FILTER)
    ) u_cs_filter (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .async_i   (bus.bus_cs_n_i),
        .level_o   (cs_level),
        .fall_o    (cs_fall),
        .rise_o    (cs_rise)
    );

    // FSM state and post-reset settle counter
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= BUS_RESYNC;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Next-state: resync until deselected, then track cs fall/rise
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        if (settle_q != SETTLE_W'(SETTLE)) begin
            settle_d = settle_q + 1'b1;
        end
        case (state_q)
            BUS_RESYNC: begin
                if ((settle_q == SETTLE_W'(SETTLE)) && cs_level) begin
                    state_d = BUS_IDLE;
                end
            end
            BUS_IDLE: begin
                if (cs_fall) begin
                    state_d = BUS_ACTIVE;
                end
            end
            BUS_ACTIVE: begin
                if (cs_rise) begin
                    state_d = BUS_IDLE;
                end
            end
            default: state_d = BUS_RESYNC;
        endcase
    end

    // Outputs: capture fields on cs fall, issue strobes, assemble words
    always_comb begin
        wr_strobe_d = 1'b0;
        rd_strobe_d = 1'b0;
        reg_num_d   = reg_num_q;
        bytesel_d   = bytesel_q;
        reg_data_d  = reg_data_q;
        hi_latch_d  = hi_latch_q;
        rd_word_d   = rd_word_q;
        bus_data_d  = bus_data_q;
        oe_d        = oe_q;

        // Register read data arrives the clock after the read strobe
        if (rd_strobe_q) begin
            rd_word_d  = reg_rd_data_i;
            bus_data_d = reg_rd_data_i[15:8];
        end

        case (state_q)
            BUS_IDLE: begin
                if (cs_fall) begin
                    reg_num_d = bus.bus_reg_num_i;
                    bytesel_d = bus.bus_bytesel_i;
                    if (bus.bus_rd_nwr_i) begin
                        oe_d = 1'b1;
                        if (bus.bus_bytesel_i == BUS_BYTE_HI) begin
                            rd_strobe_d = 1'b1;
                        end else begin
                            bus_data_d = rd_word_q[7:0];
                        end
                    end else begin
                        wr_strobe_d = 1'b1;
                        if (bus.bus_bytesel_i == BUS_BYTE_HI) begin
                            hi_latch_d = bus.bus_data_i;
                            reg_data_d = {bus.bus_data_i, reg_data_q[7:0]};
                        end else begin
                            reg_data_d = {hi_latch_q, bus.bus_data_i};
                        end
                    end
                end
            end
            BUS_ACTIVE: begin
                if (cs_rise) begin
                    oe_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and strobe registers
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_strobe_q <= 1'b0;
            rd_strobe_q <= 1'b0;
            reg_num_q   <= '0;
            bytesel_q   <= 1'b0;
            reg_data_q  <= '0;
            hi_latch_q  <= '0;
            rd_word_q   <= '0;
            bus_data_q  <= '0;
            oe_q        <= 1'b0;
        end else begin
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            reg_num_q   <= reg_num_d;
            bytesel_q   <= bytesel_d;
            reg_data_q  <= reg_data_d;
            hi_latch_q  <= hi_latch_d;
            rd_word_q   <= rd_word_d;
            bus_data_q  <= bus_data_d;
            oe_q        <= oe_d;
        end
    end

    assign reg_wr_strobe_o   = wr_strobe_q;
    assign reg_rd_strobe_o   = rd_strobe_q;
    assign reg_num_o         = reg_num_q;
    assign reg_bytesel_o     = bytesel_q;
    assign reg_data_o        = reg_data_q;
    assign bus.bus_data_o    = bus_data_q;
    assign bus.bus_data_oe_o = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_xosera_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_xosera_bus_responder
//  Description : Randomized bus-cycle bench for xosera_bus_responder with a
//                word-level model of register writes and byte reads.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_xosera_bus_responder;

    localparam real C_BUS_T = 83.333;

    logic        clk;
    logic        reset_n;
    logic        wr_strobe;
    logic        rd_strobe;
    logic [3:0]  reg_num;
    logic        reg_bytesel;
    logic [15:0] reg_data;
    logic [15:0] rd_data_drv;

    xosera_bus_responder_if bus_if ();

    xosera_bus_responder #(
        .SYNC_STAGES (2),
        .CS_FILTER   (2)
    ) dut (
        .clk             (clk),
        .reset_n_i       (reset_n),
        .bus             (bus_if),
        .reg_wr_strobe_o (wr_strobe),
        .reg_rd_strobe_o (rd_strobe),
        .reg_num_o       (reg_num),
        .reg_bytesel_o   (reg_bytesel),
        .reg_data_o      (reg_data),
        .reg_rd_data_i   (rd_data_drv)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Bench bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    // Strobe / oe observation, cleared at the start of each bus cycle
    int          wr_cnt, rd_cnt, oe_cnt, lat, fall_cyc;
    logic        lat_seen;
    logic [15:0] snap_data;

    // Word-level model of the responder's visible state
    logic [7:0]  m_hi;
    logic [15:0] m_data;
    logic [15:0] m_rdword;
    logic [7:0]  m_bus;
    logic [3:0]  m_num;
    logic        m_bsel;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic clr_obs();
        wr_cnt   = 0;
        rd_cnt   = 0;
        oe_cnt   = 0;
        lat      = 0;
        lat_seen = 1'b0;
    endtask

    task automatic model_reset();
        m_hi     = '0;
        m_data   = '0;
        m_rdword = '0;
        m_bus    = '0;
        m_num    = '0;
        m_bsel   = 1'b0;
    endtask

    always @(negedge clk) begin
        if (wr_strobe === 1'b1) begin
            wr_cnt++;
            snap_data = reg_data;
        end
        if (rd_strobe === 1'b1) rd_cnt++;
        if (bus_if.bus_data_oe_o === 1'b1) oe_cnt++;
        if ((wr_strobe === 1'b1 || rd_strobe === 1'b1) && !lat_seen) begin
            lat_seen = 1'b1;
            lat      = cyc - fall_cyc;
        end
    end

    // One full host bus cycle followed by checks against the model
    task automatic bus_cycle(input logic rd, input logic [3:0] rn, input logic bsel,
                             input logic [7:0] d, input real low_ns, input real gap_ns);
        logic exp_wr;
        logic exp_rd;
        bus_if.bus_rd_nwr_i  = rd;
        bus_if.bus_reg_num_i = rn;
        bus_if.bus_bytesel_i = bsel;
        bus_if.bus_data_i    = d;
        #7;
        clr_obs();
        fall_cyc          = cyc;
        bus_if.bus_cs_n_i = 1'b0;
        #(low_ns);
        bus_if.bus_cs_n_i = 1'b1;
        #(gap_ns);
        @(negedge clk);

        m_num  = rn;
        m_bsel = bsel;
        if (!rd) begin
            if (bsel == 1'b0) begin
                m_hi   = d;
                m_data = {d, m_data[7:0]};
            end else begin
                m_data = {m_hi, d};
            end
        end else if (bsel == 1'b0) begin
            m_rdword = rd_data_drv;
            m_bus    = m_rdword[15:8];
        end else begin
            m_bus = m_rdword[7:0];
        end
        exp_wr = !rd;
        exp_rd = rd && !bsel;

        check_val("wr_strobes", wr_cnt, {31'd0, exp_wr});
        check_val("rd_strobes", rd_cnt, {31'd0, exp_rd});
        check_val("reg_num", reg_num, m_num);
        check_val("reg_bytesel", reg_bytesel, m_bsel);
        check_val("reg_data", reg_data, m_data);
        check_val("oe_after_cycle", bus_if.bus_data_oe_o, 0);
        if (exp_wr) check_val("data_at_strobe", snap_data, m_data);
        if (rd) begin
            check_val("bus_data", bus_if.bus_data_o, m_bus);
            check_val("oe_during_read", oe_cnt != 0, 1);
        end else begin
            check_val("oe_during_write", oe_cnt, 0);
        end
        if (exp_wr || exp_rd) check_val("strobe_latency_5pm1", (lat >= 4) && (lat <= 6), 1);
    endtask

    initial begin
        reset_n              = 1'b0;
        bus_if.bus_cs_n_i    = 1'b1;
        bus_if.bus_rd_nwr_i  = 1'b0;
        bus_if.bus_reg_num_i = '0;
        bus_if.bus_bytesel_i = 1'b0;
        bus_if.bus_data_i    = '0;
        rd_data_drv          = '0;
        snap_data            = '0;
        fall_cyc             = 0;
        clr_obs();
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_wr_strobe", wr_strobe, 0);
        check_val("rst_rd_strobe", rd_strobe, 0);
        check_val("rst_reg_num", reg_num, 0);
        check_val("rst_bytesel", reg_bytesel, 0);
        check_val("rst_reg_data", reg_data, 0);
        check_val("rst_bus_data", bus_if.bus_data_o, 0);
        check_val("rst_oe", bus_if.bus_data_oe_o, 0);
        @(posedge clk);
        #5 reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // Low-byte write with no prior high write
        bus_cycle(1'b0, 4'd6, 1'b1, 8'h55, 4.0 * C_BUS_T, 4.0 * C_BUS_T);
        check_val("lo_only_0055", reg_data, 16'h0055);

        // High then low write to reg 3
        bus_cycle(1'b0, 4'd3, 1'b0, 8'h12, 4.0 * C_BUS_T, 4.0 * C_BUS_T);
        bus_cycle(1'b0, 4'd3, 1'b1, 8'h34, 4.0 * C_BUS_T, 4.0 * C_BUS_T);
        check_val("word_1234", reg_data, 16'h1234);

        // High-byte read then low-byte read with register data changed
        rd_data_drv = 16'hBEEF;
        bus_cycle(1'b1, 4'd1, 1'b0, 8'h00, 5.0 * C_BUS_T, 4.0 * C_BUS_T);
        check_val("read_hi_BE", bus_if.bus_data_o, 8'hBE);
        rd_data_drv = 16'h0000;
        bus_cycle(1'b1, 4'd1, 1'b1, 8'h00, 5.0 * C_BUS_T, 4.0 * C_BUS_T);
        check_val("read_lo_EF", bus_if.bus_data_o, 8'hEF);

        // One-clock glitch on chip select
        bus_if.bus_rd_nwr_i  = 1'b0;
        bus_if.bus_reg_num_i = 4'd9;
        bus_if.bus_bytesel_i = 1'b1;
        bus_if.bus_data_i    = 8'hA5;
        #7;
        clr_obs();
        bus_if.bus_cs_n_i = 1'b0;
        #30;
        bus_if.bus_cs_n_i = 1'b1;
        #400;
        @(negedge clk);
        check_val("glitch_strobes", wr_cnt + rd_cnt, 0);
        check_val("glitch_reg_num", reg_num, m_num);
        check_val("glitch_reg_data", reg_data, m_data);

        // Back-to-back writes with minimum gaps
        bus_cycle(1'b0, 4'd2, 1'b0, 8'hDA, 4.0 * C_BUS_T, 4.0 * C_BUS_T);
        bus_cycle(1'b0, 4'd2, 1'b1, 8'h7A, 4.0 * C_BUS_T, 4.0 * C_BUS_T);
        check_val("word_DA7A", reg_data, 16'hDA7A);

        // Reset pulsed while chip select is held low
        bus_if.bus_rd_nwr_i  = 1'b0;
        bus_if.bus_reg_num_i = 4'd5;
        bus_if.bus_bytesel_i = 1'b1;
        bus_if.bus_data_i    = 8'h99;
        #7;
        bus_if.bus_cs_n_i = 1'b0;
        #100;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #5 reset_n = 1'b1;
        clr_obs();
        model_reset();
        #600;
        bus_if.bus_cs_n_i = 1'b1;
        #400;
        @(negedge clk);
        check_val("midrst_strobes", wr_cnt + rd_cnt, 0);
        check_val("midrst_reg_data", reg_data, 0);
        check_val("midrst_reg_num", reg_num, 0);
        bus_cycle(1'b0, 4'd5, 1'b1, 8'h99, 4.0 * C_BUS_T, 4.0 * C_BUS_T);
        check_val("after_midrst_word", reg_data, 16'h0099);

        // Randomized bus cycles
        for (int i = 0; i < 40; i++) begin
            rd_data_drv = 16'($urandom);
            bus_cycle(1'($urandom), 4'($urandom), 1'($urandom), 8'($urandom),
                      4.0 * C_BUS_T + real'($urandom_range(0, 200)),
                      4.0 * C_BUS_T + real'($urandom_range(0, 150)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
